fetch_unit: RTL and testbench

//  IF stage directly upstream of decode. Owns the PC and issues 32-bit instruction reads on the ibus.

---
 rtl/fetch_unit_pkg.sv | 57 +++++
 rtl/fetch_skid_buf.sv | 44 ++++
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] PC_RESET_DEFAULT = 64'h8000_0000;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic            addr_ok;
    logic            data_ok;
    logic [ILEN-1:0] data;
  } ibus_resp_t;

  typedef enum logic [1:0] {
    PLUS4 = 2'd0,
    BEQ_N = 2'd1,
    BEQ_P = 2'd2,
    JAL_P = 2'd3
  } instfunc_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HOLD   = 2'd2,
    S_SQUASH = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [ILEN-1:0] raw_instr;
    logic [XLEN-1:0] pc;
    logic            is_bubble;
  } fetch_data_t;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } skid_entry_t;

  localparam fetch_data_t FETCH_BUBBLE = '{raw_instr: '0, pc: '0, is_bubble: 1'b1};

  function automatic logic is_taken(input instfunc_t op);
    return (op == BEQ_P) || (op == JAL_P);
  endfunction

  // Control-flow targets are halfword aligned; bit 0 is always cleared.
  function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] base,
                                                    input logic [XLEN-1:0] off);
    return (base + off) & ~XLEN'(1);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction returned while decode is stalled.
module fetch_skid_buf
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        drop_i,
  input  logic        read_i,
  input  skid_entry_t entry_i,
  output logic        full_o,
  output skid_entry_t entry_o
);

  logic        full_q, full_d;
  skid_entry_t entry_q, entry_d;

  // Load wins over a same-cycle drop/read so a fresh entry is never lost.
  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    if (drop_i || read_i) begin
      full_d = 1'b0;
    end
    if (load_i) begin
      full_d  = 1'b1;
      entry_d = entry_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end

  assign full_o  = full_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues ibus reads, squashes wrong-path fetches and
// registers the fetched instruction into decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  output ibus_req_t       ireq,
  input  ibus_resp_t      iresp,
  input  logic            stall,
  input  logic            br_valid,
  input  instfunc_t       op,
  input  logic [XLEN-1:0] offset,
  input  logic [XLEN-1:0] br_pc,
  output fetch_data_t     dataF
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  fetch_data_t     dataf_q, dataf_d;

  logic            redirect_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] pc_plus4_c;

  logic            skid_load, skid_drop, skid_read, skid_full;
  skid_entry_t     skid_out;
  logic            unused_addr_ok;

  assign redirect_c     = br_valid && !stall && is_taken(op);
  assign target_c       = branch_target(br_pc, offset);
  assign pc_plus4_c     = pc_q + XLEN'(4);
  assign unused_addr_ok = iresp.addr_ok;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (skid_load),
    .drop_i  (skid_drop),
    .read_i  (skid_read),
    .entry_i ('{instr: iresp.data, pc: pc_q}),
    .full_o  (skid_full),
    .entry_o (skid_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (iresp.data_ok) begin
          if (!redirect_c && stall) state_d = S_HOLD;
        end else if (redirect_c) begin
          state_d = S_SQUASH;
        end
      end
      S_HOLD:   if (!stall) state_d = S_FETCH;
      S_SQUASH: if (iresp.data_ok) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next values and bus request, all decoded from the current state.
  always_comb begin
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    dataf_d   = dataf_q;
    skid_load = 1'b0;
    skid_drop = 1'b0;
    skid_read = 1'b0;
    ireq      = '{valid: (state_q == S_FETCH) || (state_q == S_SQUASH), addr: pc_q};
    unique case (state_q)
      S_IDLE: dataf_d = FETCH_BUBBLE;
      S_FETCH: begin
        if (iresp.data_ok) begin
          if (redirect_c) begin
            pc_d    = target_c;
            dataf_d = FETCH_BUBBLE;
          end else if (!stall) begin
            pc_d    = pc_plus4_c;
            dataf_d = '{raw_instr: iresp.data, pc: pc_q, is_bubble: 1'b0};
          end else begin
            pc_d      = pc_plus4_c;
            skid_load = 1'b1;
          end
        end else if (redirect_c) begin
          tgt_d   = target_c;
          dataf_d = FETCH_BUBBLE;
        end else if (!stall) begin
          dataf_d = FETCH_BUBBLE;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          if (redirect_c) begin
            skid_drop = 1'b1;
            pc_d      = target_c;
            dataf_d   = FETCH_BUBBLE;
          end else begin
            skid_read = 1'b1;
            dataf_d   = '{raw_instr: skid_out.instr, pc: skid_out.pc, is_bubble: !skid_full};
          end
        end
      end
      S_SQUASH: begin
        if (!stall) dataf_d = FETCH_BUBBLE;
        if (redirect_c) tgt_d = target_c;
        if (iresp.data_ok) pc_d = redirect_c ? target_c : tgt_q;
      end
      default: dataf_d = FETCH_BUBBLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= PC_RESET;
      tgt_q   <= '0;
      dataf_q <= FETCH_BUBBLE;
    end else begin
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      dataf_q <= dataf_d;
    end
  end

  assign dataF = dataf_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit: sequential fetch, stall/skid,
// squash, redirects and asynchronous reset.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  typedef struct {
    logic            data_ok;
    logic [31:0]     data;
    logic            stall;
    logic            br_valid;
    instfunc_t       op;
    logic [63:0]     offset;
    logic [63:0]     br_pc;
    logic            exp_valid;
    logic [63:0]     exp_addr;
    logic            exp_bub;
    logic [63:0]     exp_pc;
    logic [31:0]     exp_instr;
  } vec_t;

  localparam int NVEC = 37;
  localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFF8;

  logic        clk;
  logic        reset;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        stall;
  logic        br_valid;
  instfunc_t   op;
  logic [63:0] offset;
  logic [63:0] br_pc;
  fetch_data_t dataF;

  int vectors;
  int miscompares;
  vec_t vt [NVEC];

  fetch_unit dut (
    .clk      (clk),
    .reset    (reset),
    .ireq     (ireq),
    .iresp    (iresp),
    .stall    (stall),
    .br_valid (br_valid),
    .op       (op),
    .offset   (offset),
    .br_pc    (br_pc),
    .dataF    (dataF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic dok, input logic [31:0] d, input logic st,
                              input logic bv, input instfunc_t o, input logic [63:0] off,
                              input logic [63:0] bpc, input logic ev, input logic [63:0] ea,
                              input logic eb, input logic [63:0] ep, input logic [31:0] ei);
    vec_t v;
    v.data_ok = dok; v.data = d; v.stall = st; v.br_valid = bv; v.op = o;
    v.offset = off; v.br_pc = bpc; v.exp_valid = ev; v.exp_addr = ea;
    v.exp_bub = eb; v.exp_pc = ep; v.exp_instr = ei;
    return v;
  endfunction

  task automatic check_out(input string name, input logic ev, input logic [63:0] ea,
                           input logic eb, input logic [63:0] ep, input logic [31:0] ei);
    vectors++;
    if (ireq.valid !== ev || ireq.addr !== ea || dataF.is_bubble !== eb ||
        dataF.pc !== ep || dataF.raw_instr !== ei) begin
      miscompares++;
      $display("FAIL %s: got valid=%0b addr=%h bub=%0b pc=%h instr=%h, want valid=%0b addr=%h bub=%0b pc=%h instr=%h",
               name, ireq.valid, ireq.addr, dataF.is_bubble, dataF.pc, dataF.raw_instr,
               ev, ea, eb, ep, ei);
    end
  endtask

  task automatic check_vec(input int i);
    check_out($sformatf("vec%0d", i), vt[i].exp_valid, vt[i].exp_addr, vt[i].exp_bub,
              vt[i].exp_pc, vt[i].exp_instr);
  endtask

  task automatic drive_idle();
    iresp = '0; stall = 1'b0; br_valid = 1'b0; op = PLUS4; offset = '0; br_pc = '0;
  endtask

  // At a negedge: check what the last posedge produced, then drive the next inputs.
  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      check_vec(i);
      iresp    = '{addr_ok: vt[i].data_ok, data_ok: vt[i].data_ok, data: vt[i].data};
      stall    = vt[i].stall;
      br_valid = vt[i].br_valid;
      op       = vt[i].op;
      offset   = vt[i].offset;
      br_pc    = vt[i].br_pc;
      @(negedge clk);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;

    // Sequential fetch, data_ok every second cycle.
    vt[0]  = mk(0, 32'h0,        0, 0, PLUS4, 0, 0, 0, 64'h8000_0000, 1, 0, 0);
    vt[1]  = mk(0, 32'h0,        0, 0, PLUS4, 0, 0, 1, 64'h8000_0000, 1, 0, 0);
    vt[2]  = mk(1, 32'h00000013, 0, 0, PLUS4, 0, 0, 1, 64'h8000_0000, 1, 0, 0);
    vt[3]  = mk(0, 32'h0,        0, 0, PLUS4, 0, 0, 1, 64'h8000_0004, 0, 64'h8000_0000, 32'h00000013);
    vt[4]  = mk(1, 32'h00100013, 0, 0, PLUS4, 0, 0, 1, 64'h8000_0004, 1, 0, 0);
    vt[5]  = mk(0, 32'h0,        0, 0, PLUS4, 0, 0, 1, 64'h8000_0008, 0, 64'h8000_0004, 32'h00100013);
    vt[6]  = mk(1, 32'h00200013, 0, 0, PLUS4, 0, 0, 1, 64'h8000_0008, 1, 0, 0);
    vt[7]  = mk(0, 32'h0,        0, 0, PLUS4, 0, 0, 1, 64'h8000_000C, 0, 64'h8000_0008, 32'h00200013);
    vt[8]  = mk(1, 32'h00300013, 0, 0, PLUS4, 0, 0, 1, 64'h8000_000C, 1, 0, 0);
    vt[9]  = mk(0, 32'h0,        0, 0, PLUS4, 0, 0, 1, 64'h8000_0010, 0, 64'h8000_000C, 32'h00300013);
    // Stall on the data_ok for 8000_0004, held three cycles.
    vt[10] = mk(0, 32'h0,        0, 0, PLUS4, 0, 0, 0, 64'h8000_0000, 1, 0, 0);
    vt[11] = mk(1, 32'h00a00013, 0, 0, PLUS4, 0, 0, 1, 64'h8000_0000, 1, 0, 0);
    vt[12] = mk(1, 32'h00b00013, 1, 0, PLUS4, 0, 0, 1, 64'h8000_0004, 0, 64'h8000_0000, 32'h00a00013);
    vt[13] = mk(0, 32'h0,        1, 0, PLUS4, 0, 0, 0, 64'h8000_0008, 0, 64'h8000_0000, 32'h00a00013);
    vt[14] = mk(0, 32'h0,        1, 0, PLUS4, 0, 0, 0, 64'h8000_0008, 0, 64'h8000_0000, 32'h00a00013);
    vt[15] = mk(0, 32'h0,        0, 0, PLUS4, 0, 0, 0, 64'h8000_0008, 0, 64'h8000_0000, 32'h00a00013);
    vt[16] = mk(0, 32'h0,        0, 0, PLUS4, 0, 0, 1, 64'h8000_0008, 0, 64'h8000_0004, 32'h00b00013);
    // JAL while 8000_0008 is pending: squash, then fetch 8000_0100.
    vt[17] = mk(0, 32'h0,        0, 0, PLUS4, 0, 0, 1, 64'h8000_0008, 1, 0, 0);
    vt[18] = mk(0, 32'h0,        0, 1, JAL_P, 64'h100, 64'h8000_0000, 1, 64'h8000_0008, 1, 0, 0);
    vt[19] = mk(0, 32'h0,        0, 0, PLUS4, 0, 0, 1, 64'h8000_0008, 1, 0, 0);
    vt[20] = mk(1, 32'hdead0013, 0, 0, PLUS4, 0, 0, 1, 64'h8000_0008, 1, 0, 0);
    vt[21] = mk(1, 32'h00c00013, 0, 0, PLUS4, 0, 0, 1, 64'h8000_0100, 1, 0, 0);
    // BEQ_P with offset -8 coincident with data_ok, then non-taken ops.
    vt[22] = mk(1, 32'hbad00013, 0, 1, BEQ_P, M1, 64'h8000_0010, 1, 64'h8000_0104, 0, 64'h8000_0100, 32'h00c00013);
    vt[23] = mk(1, 32'h00d00013, 0, 1, BEQ_N, 64'h40, 64'h8000_0000, 1, 64'h8000_0008, 1, 0, 0);
    vt[24] = mk(1, 32'h00e00013, 0, 0, JAL_P, 64'h40, 64'h8000_0000, 1, 64'h8000_000C, 0, 64'h8000_0008, 32'h00d00013);
    vt[25] = mk(1, 32'h00f00013, 0, 1, PLUS4, 64'h40, 64'h8000_0000, 1, 64'h8000_0010, 0, 64'h8000_000C, 32'h00e00013);
    // Taken op under stall is ignored; redirect out of S_HOLD drops the skid entry.
    vt[26] = mk(1, 32'h01000013, 1, 1, JAL_P, 64'h40, 64'h8000_0000, 1, 64'h8000_0014, 0, 64'h8000_0010, 32'h00f00013);
    vt[27] = mk(0, 32'h0,        0, 1, JAL_P, 64'h40, 64'h8000_0000, 0, 64'h8000_0018, 0, 64'h8000_0010, 32'h00f00013);
    // Two redirects during squash: newest target wins.
    vt[28] = mk(0, 32'h0,        0, 1, BEQ_P, 64'h200, 64'h8000_0000, 1, 64'h8000_0040, 1, 0, 0);
    vt[29] = mk(0, 32'h0,        0, 1, BEQ_P, 64'h200, 64'h8000_0100, 1, 64'h8000_0040, 1, 0, 0);
    vt[30] = mk(0, 32'h0,        0, 0, PLUS4, 0, 0, 1, 64'h8000_0040, 1, 0, 0);
    vt[31] = mk(1, 32'hbeef0013, 0, 0, PLUS4, 0, 0, 1, 64'h8000_0040, 1, 0, 0);
    vt[32] = mk(1, 32'h01100013, 0, 0, PLUS4, 0, 0, 1, 64'h8000_0300, 1, 0, 0);
    // Odd target is masked; a redirect on the squash data_ok cycle beats tgt_q.
    vt[33] = mk(0, 32'h0,        0, 1, JAL_P, 64'h11, 64'h8000_0300, 1, 64'h8000_0304, 0, 64'h8000_0300, 32'h01100013);
    vt[34] = mk(1, 32'hcafe0013, 0, 1, JAL_P, 64'h20, 64'h8000_0000, 1, 64'h8000_0304, 1, 0, 0);
    vt[35] = mk(1, 32'h01200013, 0, 0, PLUS4, 0, 0, 1, 64'h8000_0020, 1, 0, 0);
    vt[36] = mk(0, 32'h0,        0, 0, PLUS4, 0, 0, 1, 64'h8000_0024, 0, 64'h8000_0020, 32'h01200013);

    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    apply_range(0, 8);

    // Asynchronous reset in S_FETCH with pc=8000_0010 and a live instruction on dataF.
    check_vec(9);
    reset = 1'b1;
    #1;
    check_out("async_reset", 1'b0, 64'h8000_0000, 1'b1, 64'h0, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    apply_range(10, NVEC - 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
